// File: rtl/sr_pkg.sv
//------------------------------------------------------------------------------
// sr_pkg: shared width default and holding-register state encoding.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sr_pkg;

   localparam int SR_WIDTH_DEFAULT = 4;

   typedef enum logic [0:0] {
      HOLD_EMPTY = 1'b0,
      HOLD_FULL  = 1'b1
   } hold_state_t;

endpackage

`default_nettype wire

// File: rtl/sipo_shift_core.sv
//------------------------------------------------------------------------------
// sipo_shift_core: serial shift register and bit counter, flags word completion.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sipo_shift_core
   import sr_pkg::*;
#(
   parameter int WIDTH     = SR_WIDTH_DEFAULT,
   parameter bit MSB_FIRST = 1'b1,
   parameter int CNT_W     = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             si,
   input  logic             si_en,
   input  logic             clr,
   output logic [CNT_W-1:0] o_bit_cnt,
   output logic             o_word_done,
   output logic [WIDTH-1:0] o_word_next
);

   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] r_sreg;
   logic [WIDTH-1:0] w_sreg_shift;
   logic [CNT_W-1:0] r_cnt;
   logic             w_last;

   generate
      if (MSB_FIRST) begin : g_msb_first
         assign w_sreg_shift = {r_sreg[WIDTH-2:0], si};
      end else begin : g_lsb_first
         assign w_sreg_shift = {si, r_sreg[WIDTH-1:1]};
      end
   endgenerate

   assign w_last = (r_cnt == C_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sreg <= '0;
         r_cnt  <= '0;
      end else if (clr) begin
         r_sreg <= '0;
         r_cnt  <= '0;
      end else if (si_en) begin
         r_sreg <= w_sreg_shift;
         r_cnt  <= w_last ? '0 : r_cnt + CNT_W'(1);
      end
   end

   // The completed word includes the bit sampled on this same edge.
   assign o_word_done = si_en & ~clr & w_last;
   assign o_word_next = w_sreg_shift;
   assign o_bit_cnt   = r_cnt;

endmodule

`default_nettype wire

// File: rtl/sipo_deserializer.sv
//------------------------------------------------------------------------------
// sipo_deserializer: serial-to-parallel receiver with valid/ready holding register.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sipo_deserializer
   import sr_pkg::*;
#(
   parameter int WIDTH     = SR_WIDTH_DEFAULT,
   parameter bit MSB_FIRST = 1'b1,
   parameter int CNT_W     = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             si,
   input  logic             si_en,
   input  logic             clr,
   output logic [WIDTH-1:0] po,
   output logic             po_valid,
   input  logic             po_ready,
   output logic [CNT_W-1:0] bit_cnt,
   output logic             overrun
);

   hold_state_t      r_state;
   hold_state_t      w_state_next;
   logic [WIDTH-1:0] r_po;
   logic [WIDTH-1:0] w_po_next;
   logic             r_ovr;
   logic             w_ovr_next;
   logic             w_word_done;
   logic [WIDTH-1:0] w_word_next;

   sipo_shift_core #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST),
      .CNT_W     (CNT_W)
   ) u_core (
      .clk         (clk),
      .reset       (reset),
      .si          (si),
      .si_en       (si_en),
      .clr         (clr),
      .o_bit_cnt   (bit_cnt),
      .o_word_done (w_word_done),
      .o_word_next (w_word_next)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= HOLD_EMPTY;
         r_po    <= '0;
         r_ovr   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_po    <= w_po_next;
         r_ovr   <= w_ovr_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_po_next    = r_po;
      w_ovr_next   = r_ovr;
      case (r_state)
         HOLD_EMPTY: begin
            if (w_word_done) begin
               w_po_next    = w_word_next;
               w_state_next = HOLD_FULL;
            end
         end
         HOLD_FULL: begin
            // A drain and a completion on one edge hand over without a bubble.
            if (w_word_done && po_ready) begin
               w_po_next = w_word_next;
            end else if (w_word_done) begin
               w_ovr_next = 1'b1;
            end else if (po_ready) begin
               w_state_next = HOLD_EMPTY;
            end
         end
         default: w_state_next = HOLD_EMPTY;
      endcase
      if (clr) begin
         w_ovr_next = 1'b0;
      end
   end

   assign po       = r_po;
   assign po_valid = (r_state == HOLD_FULL);
   assign overrun  = r_ovr;

endmodule

`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
//------------------------------------------------------------------------------
// tb_sipo_deserializer: MSB-first and LSB-first instances driven by one stream.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sipo_deserializer;

   logic       clk;
   logic       reset;
   logic       si;
   logic       si_en;
   logic       clr;
   logic       po_ready;
   logic [3:0] po_m;
   logic [3:0] po_l;
   logic       valid_m;
   logic       valid_l;
   logic [1:0] cnt_m;
   logic [1:0] cnt_l;
   logic       ovr_m;
   logic       ovr_l;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] sb[$];

   typedef struct {
      logic [3:0] stream;
      bit         rand_gap;
      logic [3:0] exp_m;
      logic [3:0] exp_l;
   } vec_t;

   vec_t vecs[6];

   sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1), .CNT_W(2)) dut_m (
      .clk(clk), .reset(reset), .si(si), .si_en(si_en), .clr(clr),
      .po(po_m), .po_valid(valid_m), .po_ready(po_ready),
      .bit_cnt(cnt_m), .overrun(ovr_m)
   );

   sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0), .CNT_W(2)) dut_l (
      .clk(clk), .reset(reset), .si(si), .si_en(si_en), .clr(clr),
      .po(po_l), .po_valid(valid_l), .po_ready(po_ready),
      .bit_cnt(cnt_l), .overrun(ovr_l)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_state(input string tag, input logic [3:0] em, input logic [3:0] el,
                            input logic v, input logic [1:0] c, input logic o);
      chk({tag, ".po_m"},    32'(po_m),    32'(em));
      chk({tag, ".po_l"},    32'(po_l),    32'(el));
      chk({tag, ".valid_m"}, 32'(valid_m), 32'(v));
      chk({tag, ".valid_l"}, 32'(valid_l), 32'(v));
      chk({tag, ".cnt_m"},   32'(cnt_m),   32'(c));
      chk({tag, ".cnt_l"},   32'(cnt_l),   32'(c));
      chk({tag, ".ovr_m"},   32'(ovr_m),   32'(o));
      chk({tag, ".ovr_l"},   32'(ovr_l),   32'(o));
   endtask

   // A transfer happens on the next edge whenever valid and ready are both high.
   always @(negedge clk) begin
      if (!reset && valid_m && po_ready) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'(sb.size()), 32'd1);
         end else begin
            logic [7:0] e;
            e = sb.pop_front();
            chk("sb_po_m", 32'(po_m), 32'(e[7:4]));
            chk("sb_po_l", 32'(po_l), 32'(e[3:0]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      si    = b;
      si_en = 1'b1;
      tick();
      si_en = 1'b0;
      si    = 1'b0;
   endtask

   task automatic expect_word(input logic [3:0] w);
      logic [3:0] em;
      logic [3:0] el;
      for (int i = 0; i < 4; i++) begin
         em[3-i] = w[3-i];
         el[i]   = w[3-i];
      end
      sb.push_back({em, el});
   endtask

   // Bits go out w[3] first; optional random idle cycles between bits.
   task automatic send_word(input logic [3:0] w, input bit rand_gap, input bit deliver);
      if (deliver) expect_word(w);
      for (int i = 0; i < 4; i++) begin
         drive_bit(w[3-i]);
         if (rand_gap && i < 3) repeat ($urandom_range(0, 3)) tick();
      end
   endtask

   task automatic pulse_ready();
      po_ready = 1'b1;
      tick();
      po_ready = 1'b0;
   endtask

   initial begin
      vecs[0] = '{stream: 4'b1011, rand_gap: 1'b0, exp_m: 4'b1011, exp_l: 4'b1101};
      vecs[1] = '{stream: 4'b1011, rand_gap: 1'b1, exp_m: 4'b1011, exp_l: 4'b1101};
      vecs[2] = '{stream: 4'b0001, rand_gap: 1'b0, exp_m: 4'b0001, exp_l: 4'b1000};
      vecs[3] = '{stream: 4'b1110, rand_gap: 1'b1, exp_m: 4'b1110, exp_l: 4'b0111};
      vecs[4] = '{stream: 4'b0110, rand_gap: 1'b0, exp_m: 4'b0110, exp_l: 4'b0110};
      vecs[5] = '{stream: 4'b1100, rand_gap: 1'b1, exp_m: 4'b1100, exp_l: 4'b0011};

      reset    = 1'b1;
      si       = 1'b0;
      si_en    = 1'b0;
      clr      = 1'b0;
      po_ready = 1'b0;
      #20;
      chk_state("reset", 4'h0, 4'h0, 1'b0, 2'd0, 1'b0);
      #20;
      reset = 1'b0;
      tick();

      for (int k = 0; k < 6; k++) begin
         send_word(vecs[k].stream, vecs[k].rand_gap, 1'b1);
         chk_state($sformatf("vec%0d", k), vecs[k].exp_m, vecs[k].exp_l, 1'b1, 2'd0, 1'b0);
         pulse_ready();
         chk_state($sformatf("vec%0d_drain", k), vecs[k].exp_m, vecs[k].exp_l, 1'b0, 2'd0, 1'b0);
         pulse_ready();
         chk($sformatf("vec%0d_idle_ready", k), 32'(valid_m), 32'd0);
      end

      // Back-to-back with po_ready held high.
      begin
         logic [7:0] stream;
         stream = 8'b0010_0101;
         expect_word(4'b0010);
         expect_word(4'b0101);
         po_ready = 1'b1;
         for (int i = 0; i < 8; i++) begin
            drive_bit(stream[7-i]);
            if (i == 3) chk_state("b2b_w1", 4'b0010, 4'b0100, 1'b1, 2'd0, 1'b0);
            if (i == 4) chk("b2b_gap_valid", 32'(valid_m), 32'd0);
            if (i == 7) chk_state("b2b_w2", 4'b0101, 4'b1010, 1'b1, 2'd0, 1'b0);
         end
         tick();
         chk("b2b_end_valid", 32'(valid_l), 32'd0);
         po_ready = 1'b0;
      end

      // Overrun: second word dropped, old word held.
      send_word(4'b1000, 1'b0, 1'b1);
      send_word(4'b1100, 1'b0, 1'b0);
      chk_state("ovr_set", 4'b1000, 4'b0001, 1'b1, 2'd0, 1'b1);
      pulse_ready();
      chk_state("ovr_drain", 4'b1000, 4'b0001, 1'b0, 2'd0, 1'b1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk_state("ovr_clr", 4'b1000, 4'b0001, 1'b0, 2'd0, 1'b0);

      // clr mid-word while a word is pending; the strobed bit is discarded.
      send_word(4'b0100, 1'b0, 1'b1);
      drive_bit(1'b0);
      drive_bit(1'b1);
      chk("clr_pre_cnt", 32'(cnt_m), 32'd2);
      clr   = 1'b1;
      si    = 1'b1;
      si_en = 1'b1;
      tick();
      clr   = 1'b0;
      si_en = 1'b0;
      si    = 1'b0;
      chk_state("clr_mid", 4'b0100, 4'b0010, 1'b1, 2'd0, 1'b0);
      pulse_ready();
      send_word(4'b0001, 1'b0, 1'b1);
      chk_state("clr_next", 4'b0001, 4'b1000, 1'b1, 2'd0, 1'b0);
      pulse_ready();

      // Asynchronous reset between edges, mid-word with a word pending.
      send_word(4'b1010, 1'b0, 1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      drive_bit(1'b0);
      chk_state("ar_pre", 4'b1010, 4'b0101, 1'b1, 2'd3, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      chk_state("ar_async", 4'h0, 4'h0, 1'b0, 2'd0, 1'b0);
      #2;
      reset = 1'b0;
      tick();
      send_word(4'b0111, 1'b0, 1'b1);
      chk_state("ar_fresh", 4'b0111, 4'b1110, 1'b1, 2'd0, 1'b0);
      pulse_ready();
      tick();

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
